// File: rtl/flatten_collector.sv
// Serial-to-parallel pixel collector for the BNN final layer: fills a NUM_INPUTS-bit vector, then holds it.
// Optional sticky protocol checking is enabled by defining FLATTEN_OVERRUN_CHECK_EN.
module flatten_collector #(
  parameter int NUM_INPUTS = 196
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  frame_start,
  input  logic                  pixel_valid,
  input  logic                  pixel_bit,
  input  logic                  layer_done,
  output logic                  pixel_ready,
  output logic [NUM_INPUTS-1:0] data_out,
  output logic                  layer_en,
  output logic                  frame_done,
  output logic                  overrun_err
);

  localparam int         IDX_W = $clog2(NUM_INPUTS);
  localparam logic [7:0] LAST  = 8'(NUM_INPUTS - 1);

  typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;

  state_t                  state_q;
  logic [7:0]              count_q;
  logic [NUM_INPUTS-1:0]   data_q;
  logic                    frame_done_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      count_q      <= 8'd0;
      data_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE, FILL: begin
          // A new frame discards any partial one; a coincident pixel lands at index 0.
          if (frame_start) begin
            state_q <= FILL;
            if (pixel_valid) begin
              data_q  <= NUM_INPUTS'(pixel_bit);
              count_q <= 8'd1;
            end else begin
              data_q  <= '0;
              count_q <= 8'd0;
            end
          end else if (state_q == FILL && pixel_valid) begin
            data_q[count_q[IDX_W-1:0]] <= pixel_bit;
            if (count_q == LAST) begin
              state_q <= HOLD;
              count_q <= 8'd0;
            end else begin
              count_q <= count_q + 8'd1;
            end
          end
        end
        HOLD: begin
          if (layer_done) begin
            state_q      <= IDLE;
            frame_done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_out    = data_q;
  assign layer_en    = (state_q == HOLD);
  assign pixel_ready = (state_q != HOLD);
  assign frame_done  = frame_done_q;

`ifdef FLATTEN_OVERRUN_CHECK_EN
  logic err_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if ((state_q == HOLD && pixel_valid) ||
                 (state_q == IDLE && pixel_valid && !frame_start) ||
                 (state_q == FILL && frame_start && count_q != 8'd0)) begin
      err_q <= 1'b1;
    end
  end

  assign overrun_err = err_q;
`else
  assign overrun_err = 1'b0;
`endif

endmodule

// File: tb/tb_flatten_collector.sv
// Self-checking bench for flatten_collector: directed scenarios plus randomized traffic against a frame-level model.
module tb_flatten_collector;
  localparam int N = 196;
`ifdef FLATTEN_OVERRUN_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         frame_start = 1'b0;
  logic         pixel_valid = 1'b0;
  logic         pixel_bit = 1'b0;
  logic         layer_done = 1'b0;
  logic         pixel_ready;
  logic [N-1:0] data_out;
  logic         layer_en;
  logic         frame_done;
  logic         overrun_err;

  int checks = 0;
  int errors = 0;

  flatten_collector #(.NUM_INPUTS(N)) dut (
    .clock      (clock),
    .reset      (reset),
    .frame_start(frame_start),
    .pixel_valid(pixel_valid),
    .pixel_bit  (pixel_bit),
    .layer_done (layer_done),
    .pixel_ready(pixel_ready),
    .data_out   (data_out),
    .layer_en   (layer_en),
    .frame_done (frame_done),
    .overrun_err(overrun_err)
  );

  always #5 clock = ~clock;

  // Frame-level reference: phase 0 = waiting, 1 = collecting, 2 = presenting the frame.
  int           m_ph;
  int           m_cnt;
  logic [N-1:0] m_vec;
  bit           m_done;
  bit           m_err;

  always @(posedge clock or negedge reset) begin : model
    int           ph;
    int           cnt;
    logic [N-1:0] vec;
    bit           err;
    bit           done;
    if (!reset) begin
      m_ph <= 0; m_cnt <= 0; m_vec <= '0; m_done <= 1'b0; m_err <= 1'b0;
    end else begin
      ph = m_ph; cnt = m_cnt; vec = m_vec; err = m_err; done = 1'b0;
      if (ph == 2) begin
        if (pixel_valid) err = 1'b1;
        if (layer_done) begin ph = 0; done = 1'b1; end
      end else begin
        if (frame_start) begin
          if (ph == 1 && cnt != 0) err = 1'b1;
          ph = 1; cnt = 0; vec = '0;
        end else if (ph == 0 && pixel_valid) begin
          err = 1'b1;
        end
        if (ph == 1 && pixel_valid) begin
          vec[cnt] = pixel_bit;
          cnt++;
          if (cnt == N) begin ph = 2; cnt = 0; end
        end
      end
      m_ph <= ph; m_cnt <= cnt; m_vec <= vec; m_done <= done; m_err <= err;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    frame_start = 1'b0; pixel_valid = 1'b0; pixel_bit = 1'b0; layer_done = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    tick(); tick();
    checks++;
    if (data_out !== '0 || layer_en !== 1'b0 || frame_done !== 1'b0 ||
        overrun_err !== 1'b0 || pixel_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset: data=%h en=%b fd=%b err=%b rdy=%b, want 0 0 0 0 1",
               data_out, layer_en, frame_done, overrun_err, pixel_ready);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_full_frame();
    logic [N-1:0] exp;
    int early = 0;
    exp = '0;
    for (int k = 0; k < N; k++) begin
      exp[k] = 1'(k % 2);
      frame_start = (k == 0);
      pixel_valid = 1'b1;
      pixel_bit   = 1'(k % 2);
      tick();
      if (k < N - 1 && layer_en !== 1'b0) early++;
    end
    idle_inputs();
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL full_early_en: layer_en high on %0d fill cycles, want 0", early);
    end
    checks++;
    if (layer_en !== 1'b1 || pixel_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_hold: en=%b rdy=%b, want 1 0", layer_en, pixel_ready);
    end
    checks++;
    if (data_out !== exp) begin
      errors++;
      $display("FAIL full_data: got %h want %h", data_out, exp);
    end
  endtask

  task automatic test_hold_release();
    logic [N-1:0] held;
    held = data_out;
    tick();
    tick();
    layer_done = 1'b1;
    checks++;
    if (data_out !== held || layer_en !== 1'b1) begin
      errors++;
      $display("FAIL hold_stable: data=%h en=%b, want %h 1", data_out, layer_en, held);
    end
    tick();
    layer_done = 1'b0;
    checks++;
    if (frame_done !== 1'b1 || layer_en !== 1'b0 || pixel_ready !== 1'b1) begin
      errors++;
      $display("FAIL release: fd=%b en=%b rdy=%b, want 1 0 1", frame_done, layer_en, pixel_ready);
    end
    tick();
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: frame_done=%b second cycle, want 0", frame_done);
    end
  endtask

  task automatic test_restart();
    int cyc = 0;
    for (int k = 0; k < 100; k++) begin
      frame_start = (k == 0);
      pixel_valid = 1'b1;
      pixel_bit   = 1'($urandom);
      tick();
    end
    frame_start = 1'b1;
    pixel_valid = 1'b1;
    pixel_bit   = 1'b1;
    while (layer_en !== 1'b1 && cyc < 400) begin
      tick();
      frame_start = 1'b0;
      cyc++;
    end
    idle_inputs();
    checks++;
    if (cyc != N) begin
      errors++;
      $display("FAIL restart_len: HOLD after %0d cycles, want %0d", cyc, N);
    end
    checks++;
    if (data_out !== {N{1'b1}}) begin
      errors++;
      $display("FAIL restart_data: got %h want all ones", data_out);
    end
  endtask

  task automatic test_overrun();
    logic [N-1:0] held;
    held = data_out;
    pixel_valid = 1'b1;
    pixel_bit   = ~held[0];
    tick();
    tick();
    pixel_valid = 1'b0;
    checks++;
    if (data_out !== held || layer_en !== 1'b1) begin
      errors++;
      $display("FAIL overrun_data: data=%h en=%b, want %h 1", data_out, layer_en, held);
    end
    layer_done = 1'b1;
    tick();
    layer_done = 1'b0;
    tick(); tick();
    checks++;
    if (overrun_err !== ERR_EN) begin
      errors++;
      $display("FAIL overrun_flag: got %b want %b", overrun_err, ERR_EN);
    end
  endtask

  task automatic test_reset_in_hold();
    for (int k = 0; k < N; k++) begin
      frame_start = (k == 0);
      pixel_valid = 1'b1;
      pixel_bit   = 1'b1;
      tick();
    end
    idle_inputs();
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (layer_en !== 1'b0 || data_out !== '0 || frame_done !== 1'b0 ||
        pixel_ready !== 1'b1 || overrun_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: en=%b data=%h fd=%b rdy=%b err=%b, want 0 0 0 1 0",
               layer_en, data_out, frame_done, pixel_ready, overrun_err);
    end
    tick();
    reset = 1'b1;
    tick();
    for (int k = 0; k < N; k++) begin
      frame_start = (k == 0);
      pixel_valid = 1'b1;
      pixel_bit   = (k == 5);
      tick();
    end
    idle_inputs();
    checks++;
    if (layer_en !== 1'b1 || data_out !== (N'(1) << 5)) begin
      errors++;
      $display("FAIL after_reset_frame: en=%b data=%h, want 1 with bit 5 only", layer_en, data_out);
    end
  endtask

  task automatic test_back_to_back();
    int cyc = 0;
    layer_done = 1'b1;
    tick();
    layer_done  = 1'b0;
    frame_start = 1'b1;
    pixel_valid = 1'b1;
    pixel_bit   = 1'b1;
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done: frame_done=%b want 1", frame_done);
    end
    tick();
    frame_start = 1'b0;
    pixel_bit   = 1'b0;
    checks++;
    if (data_out !== N'(1) || layer_en !== 1'b0) begin
      errors++;
      $display("FAIL b2b_pixel0: data=%h en=%b, want 1 0", data_out, layer_en);
    end
    while (layer_en !== 1'b1 && cyc < 400) begin
      tick();
      cyc++;
    end
    idle_inputs();
    checks++;
    if (cyc != N - 1 || data_out !== N'(1)) begin
      errors++;
      $display("FAIL b2b_count: %0d more pixels, data=%h; want %0d and 1", cyc, data_out, N - 1);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int c = 0; c < 6000; c++) begin
      frame_start = ($urandom_range(0, 299) == 0);
      pixel_valid = ($urandom_range(0, 3) != 0);
      pixel_bit   = 1'($urandom);
      layer_done  = ($urandom_range(0, 3) == 0);
      tick();
      checks++;
      if (data_out !== m_vec || layer_en !== (m_ph == 2) || pixel_ready !== (m_ph != 2) ||
          frame_done !== m_done || overrun_err !== (ERR_EN & m_err)) begin
        errors++;
        if (bad < 10)
          $display("FAIL random c%0d: en=%b rdy=%b fd=%b err=%b data_ok=%b; want en=%b fd=%b err=%b",
                   c, layer_en, pixel_ready, frame_done, overrun_err, data_out === m_vec,
                   m_ph == 2, m_done, ERR_EN & m_err);
        bad++;
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_hold_release();
    test_restart();
    test_overrun();
    test_reset_in_hold();
    test_back_to_back();
    test_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
